// File: rtl/ram_bank_sp.sv
// Single-port synchronous RAM bank (one byte lane) with a registered one-cycle read port.
// Optional RAM_BANK_WR_FWD_EN selects write-first forwarding on same-address read/write.
module ram_bank_sp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;
  logic             w_in_range;
  logic             w_wr_en;

  // One extra bit so DEPTH == 2^AW is representable in the compare.
  assign w_in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
  assign w_wr_en    = rst_n && we && w_in_range;

  // Array has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[addr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (!w_in_range) begin
      r_q <= '0;
`ifdef RAM_BANK_WR_FWD_EN
    end else if (we) begin
      r_q <= d;
`endif
    end else begin
      r_q <= r_mem[addr];
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_ram_bank_sp.sv
// Directed, table-driven bench for ram_bank_sp: a DEPTH=256 bank driven from a vector
// table and a DEPTH=200 bank exercised with a hand-written out-of-range sequence.
module tb_ram_bank_sp;

  localparam int unsigned ModeNone = 0;
  localparam int unsigned ModeEq   = 1;
  localparam int unsigned ModeNe   = 2;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  d;
    int unsigned mode;
    logic [7:0]  exp_q;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [7:0] d;
  logic [7:0] addr;
  logic [7:0] q;

  logic       b_rst_n;
  logic       b_we;
  logic [7:0] b_d;
  logic [7:0] b_addr;
  logic [7:0] b_q;

  int n_checks;
  int n_fail;

  vec_t vecs[$];

  ram_bank_sp #(
    .WIDTH(8),
    .AW   (8),
    .DEPTH(256)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .d    (d),
    .addr (addr),
    .q    (q)
  );

  ram_bank_sp #(
    .WIDTH(8),
    .AW   (8),
    .DEPTH(200)
  ) u_dut_short (
    .clk  (clk),
    .rst_n(b_rst_n),
    .we   (b_we),
    .d    (b_d),
    .addr (b_addr),
    .q    (b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic w, input logic [7:0] a, input logic [7:0] dd,
                     input int unsigned m, input logic [7:0] e);
    vec_t v;
    v.rst_n = r;
    v.we    = w;
    v.addr  = a;
    v.d     = dd;
    v.mode  = m;
    v.exp_q = e;
    vecs.push_back(v);
  endtask

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q=%h, expected %h", name, act, exp);
    end
  endtask

  // One cycle on the short bank: drive at negedge, sample at the following negedge.
  task automatic step_b(input logic r, input logic w, input logic [7:0] a, input logic [7:0] dd);
    b_rst_n = r;
    b_we    = w;
    b_addr  = a;
    b_d     = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rdw_exp;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; we = 1'b0; addr = '0; d = '0;
    b_rst_n = 1'b0; b_we = 1'b0; b_addr = '0; b_d = '0;

`ifdef RAM_BANK_WR_FWD_EN
    rdw_exp = 8'h22;
`else
    rdw_exp = 8'h11;
`endif

    // Reset held with a write pending: q stays 0 and the write is dropped.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 8'h10, 8'hAA, ModeEq, 8'h00);
    add(1'b1, 1'b0, 8'h10, 8'h00, ModeNe, 8'hAA);
    // Basic write then read, including the top address.
    add(1'b1, 1'b1, 8'h03, 8'h5A, ModeNone, 8'h00);
    add(1'b1, 1'b1, 8'hFF, 8'hC3, ModeNone, 8'h00);
    add(1'b1, 1'b0, 8'h03, 8'h00, ModeEq,   8'h5A);
    add(1'b1, 1'b0, 8'hFF, 8'h00, ModeEq,   8'hC3);
    // Write at edge N readable by an address presented for edge N+1.
    add(1'b1, 1'b1, 8'h30, 8'h66, ModeNone, 8'h00);
    add(1'b1, 1'b0, 8'h30, 8'h00, ModeEq,   8'h66);
    // Read-during-write to the same address.
    add(1'b1, 1'b1, 8'h20, 8'h11, ModeNone, 8'h00);
    add(1'b1, 1'b1, 8'h20, 8'h22, ModeEq,   rdw_exp);
    add(1'b1, 1'b0, 8'h20, 8'h00, ModeEq,   8'h22);
    // Reset on the edge that samples the read address drops the read.
    add(1'b1, 1'b1, 8'h40, 8'h9C, ModeNone, 8'h00);
    add(1'b0, 1'b0, 8'h40, 8'h00, ModeEq,   8'h00);
    add(1'b1, 1'b0, 8'h40, 8'h00, ModeEq,   8'h9C);
    // Known word survives a reset cycle that also attempts to overwrite it.
    add(1'b1, 1'b1, 8'h10, 8'h55, ModeNone, 8'h00);
    add(1'b0, 1'b1, 8'h10, 8'hAA, ModeEq,   8'h00);
    add(1'b1, 1'b0, 8'h10, 8'h00, ModeEq,   8'h55);
    // Streaming: 256 back-to-back writes, then 256 back-to-back reads.
    for (int i = 0; i < 256; i++) add(1'b1, 1'b1, 8'(i), 8'(i) ^ 8'hFF, ModeNone, 8'h00);
    for (int i = 0; i < 256; i++) add(1'b1, 1'b0, 8'(i), 8'h00, ModeEq, 8'(i) ^ 8'hFF);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      we    = vecs[i].we;
      addr  = vecs[i].addr;
      d     = vecs[i].d;
      @(posedge clk);
      @(negedge clk);
      if (vecs[i].mode == ModeEq) begin
        n_checks++;
        if (q !== vecs[i].exp_q) begin
          n_fail++;
          $display("FAIL vec[%0d] addr=%h: q=%h, expected %h", i, vecs[i].addr, q,
                   vecs[i].exp_q);
        end
      end else if (vecs[i].mode == ModeNe) begin
        n_checks++;
        if (q === vecs[i].exp_q) begin
          n_fail++;
          $display("FAIL vec[%0d] addr=%h: q=%h, expected anything but %h", i, vecs[i].addr,
                   q, vecs[i].exp_q);
        end
      end
    end
    we = 1'b0;

    // DEPTH=200 bank: address 200 is out of range for both write and read.
    step_b(1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("short_reset", b_q, 8'h00);
    step_b(1'b1, 1'b1, 8'hC7, 8'h44);
    step_b(1'b1, 1'b0, 8'hC7, 8'h00);
    check_eq("short_last_word", b_q, 8'h44);
    step_b(1'b1, 1'b1, 8'hC8, 8'h77);
    check_eq("short_oor_write_q", b_q, 8'h00);
    step_b(1'b1, 1'b0, 8'hC8, 8'h00);
    check_eq("short_oor_read", b_q, 8'h00);
    step_b(1'b1, 1'b0, 8'hC7, 8'h00);
    check_eq("short_neighbour_kept", b_q, 8'h44);
    step_b(1'b1, 1'b0, 8'hFF, 8'h00);
    check_eq("short_oor_top", b_q, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bank_sp.md
# ram_bank_sp

Single-port synchronous RAM bank, one byte lane of the byte-enabled data memory. The memory wrapper instantiates one bank per byte lane, with all lanes sharing the word address and each lane gating its own write strobe from the byte enables. The bank provides one write port and a registered read port with a fixed one-cycle read latency.

## Interface
Parameters (positional order: WIDTH, AW, DEPTH):
- WIDTH, default 8: data width in bits.
- AW, default 8: address width in bits.
- DEPTH, default 1<<AW: number of words; legal range 1..2^AW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- we  input  1  write strobe.
- d  input  WIDTH  write data.
- addr  input  AW  word address, shared by read and write.
- q  output  WIDTH  registered read data.

## Operation
- Storage: DEPTH words of WIDTH bits. Reset does not clear the array. Contents are undefined (X in simulation) until written.
- Write: when rst_n=1, we=1 and addr<DEPTH, mem[addr] <= d at the rising edge.
- Suppressed writes:
  - we=1 with addr>=DEPTH is ignored, and no other word changes.
  - Any write while rst_n=0 is ignored.
- Read: there is no read enable. Every cycle with rst_n=1, q <= mem[addr] if addr<DEPTH, otherwise q <= 0.
- Read-during-write to the same address (macro off): q returns the old contents (read-before-write). The new data is visible on the next read.
- Reset: while rst_n=0 at a rising edge, q <= 0 and no write occurs.
  - Reset asserted mid-stream drops an in-flight read: q is 0 on the cycle after the reset edge.
  - Memory contents survive reset.
- Arithmetic: no width conversion. d and q are exactly WIDTH bits, and addr is compared unsigned against DEPTH.

## Timing
- Read latency: exactly 1 cycle. addr is sampled at edge N, and q is valid after edge N and held until edge N+1.
- Write latency: data written at edge N is readable by an address presented for edge N+1, appearing on q after edge N+1.
- Back-to-back accesses are allowed every cycle with no stalls or handshake.
- Reset value of q: all zeros. q is the only output.
- Synthesis intent: the array infers as block RAM with a synchronous read; there is no combinational path from addr or d to q.

## Configuration
- Macro RAM_BANK_WR_FWD_EN.
- Defined: write-first forwarding. On a same-cycle write and read to the same in-range address with rst_n=1, q <= d (the new data), and the array is also updated.
- Undefined: read-before-write as in Operation. q shows the previous contents.
- All other behaviour is identical in both builds.

## Test plan
Default parameters WIDTH=8, AW=8, DEPTH=256 unless stated otherwise.
- Reset: hold rst_n=0 for 3 cycles with we=1, addr=0x10, d=0xAA, then release and read 0x10 -> q=0x00 during reset, and the word at 0x10 is not 0xAA (the write was suppressed).
- Write/read: write 0x5A@0x03 and 0xC3@0xFF, then read 0x03 then 0xFF -> q=0x5A one cycle after the 0x03 read, then q=0xC3 the next cycle.
- Read-during-write: preload 0x11@0x20, then in one cycle we=1, addr=0x20, d=0x22 -> q=0x11 without the macro (0x22 with RAM_BANK_WR_FWD_EN); the next read of 0x20 -> q=0x22 in both builds.
- Out-of-range: DEPTH=200; write 0x77@0xC8 (200), then read 0xC8 -> q=0x00; a read of 0xC7 is unchanged from its prior value.
- Streaming: write addr i with data i^0xFF for i=0..255 on consecutive cycles, then read 0..255 back-to-back -> q=i^0xFF one cycle after each address, with no gaps.
- Reset mid-read: read a preloaded 0x9C@0x40, asserting rst_n=0 on the same edge that samples addr=0x40 -> q=0x00; after release, reread 0x40 -> q=0x9C (contents retained).
